// File: rtl/phase_scheduler_if.sv
// Handshake/bus bundle for phase_scheduler: control inputs, programmed durations and
// the phase/slot status outputs. Clock and reset stay outside as plain ports.
interface phase_scheduler_if #(
  parameter int NCH = 3,
  parameter int W   = 5
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             hold;
  logic [NCH-1:0]   ch_en;
  logic [NCH*W-1:0] dur;
  logic [NCH-1:0]   phase_onehot;
  logic [1:0]       phase_addr;
  logic [W-1:0]     remaining;
  logic             busy;
  logic             phase_done;
  logic             frame_done;

  modport master (
    output tick, start, stop, hold, ch_en, dur,
    input  phase_onehot, phase_addr, remaining, busy, phase_done, frame_done
  );

  modport slave (
    input  tick, start, stop, hold, ch_en, dur,
    output phase_onehot, phase_addr, remaining, busy, phase_done, frame_done
  );
endinterface

// File: rtl/phase_scheduler.sv
// Round-robin slot scheduler: steps a one-hot/binary phase through enabled channels,
// holding each for dur_i+1 ticks, with pulses at every slot end and round-robin wrap.
module phase_scheduler #(
  parameter int NCH = 3,
  parameter int W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  phase_scheduler_if.slave  bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state, w_state_next;
  logic [1:0]     r_idx, w_idx_next;
  logic [W-1:0]   r_cnt, w_cnt_next;
  logic [W-1:0]   r_dur, w_dur_next;
  logic [NCH-1:0] r_onehot, w_onehot_next;
  logic [1:0]     r_addr, w_addr_next;
  logic [W-1:0]   r_remaining, w_remaining_next;
  logic           r_busy, w_busy_next;
  logic           r_phase_done, w_phase_done_next;
  logic           r_frame_done, w_frame_done_next;

  logic [1:0]     w_first_idx;
  logic [1:0]     w_wrap_idx;
  logic [1:0]     w_cand;

  // Lowest enabled channel for start; first enabled after r_idx (wrapping to itself) for slot end.
  always_comb begin
    w_first_idx = '0;
    w_wrap_idx  = r_idx;
    w_cand      = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.ch_en[k]) w_first_idx = 2'(k);
    end
    for (int k = NCH; k >= 1; k--) begin
      w_cand = 2'((int'(r_idx) + k) % NCH);
      if (bus.ch_en[w_cand]) w_wrap_idx = w_cand;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_cnt_next        = r_cnt;
    w_dur_next        = r_dur;
    w_phase_done_next = 1'b0;
    w_frame_done_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop && (|bus.ch_en)) begin
          w_state_next = S_RUN;
          w_idx_next   = w_first_idx;
          w_cnt_next   = '0;
          w_dur_next   = bus.dur[w_first_idx*W +: W];
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
          w_dur_next   = '0;
        end else if (bus.hold) begin
          w_cnt_next = r_cnt;
        end else if (bus.tick) begin
          if (r_cnt != r_dur) begin
            w_cnt_next = r_cnt + 1'b1;
          end else begin
            w_phase_done_next = 1'b1;
            w_cnt_next        = '0;
            if (bus.ch_en == '0) begin
              // Nothing left to schedule: close the frame and drop back to idle.
              w_frame_done_next = 1'b1;
              w_state_next      = S_IDLE;
              w_idx_next        = '0;
              w_dur_next        = '0;
            end else begin
              w_frame_done_next = (w_wrap_idx <= r_idx);
              w_idx_next        = w_wrap_idx;
              w_dur_next        = bus.dur[w_wrap_idx*W +: W];
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_busy_next      = (w_state_next == S_RUN);
    w_onehot_next    = w_busy_next ? ({{(NCH-1){1'b0}}, 1'b1} << w_idx_next) : '0;
    w_addr_next      = w_busy_next ? w_idx_next : 2'b11;
    w_remaining_next = w_busy_next ? (w_dur_next - w_cnt_next) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_dur        <= '0;
      r_onehot     <= '0;
      r_addr       <= 2'b11;
      r_remaining  <= '0;
      r_busy       <= 1'b0;
      r_phase_done <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_dur        <= w_dur_next;
      r_onehot     <= w_onehot_next;
      r_addr       <= w_addr_next;
      r_remaining  <= w_remaining_next;
      r_busy       <= w_busy_next;
      r_phase_done <= w_phase_done_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign bus.phase_onehot = r_onehot;
  assign bus.phase_addr   = r_addr;
  assign bus.remaining    = r_remaining;
  assign bus.busy         = r_busy;
  assign bus.phase_done   = r_phase_done;
  assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: stimulus pushes expected slot-end events into a
// scoreboard; a negedge monitor pops and compares whenever phase_done pulses.
module tb_phase_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic [2:0] oh;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   base;

  int exp_addr1[8] = '{0, 1, 1, 2, 2, 2, 0, 1};
  int exp_rem1[8]  = '{0, 1, 0, 2, 1, 0, 0, 1};

  phase_scheduler_if #(.NCH(3), .W(5)) bus ();

  phase_scheduler #(.NCH(3), .W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [1:0] a, input logic fd);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.oh   = (a == 2'b11) ? 3'b000 : (3'b001 << a);
    e.fd   = fd;
    sb.push_back(e);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"},   bus.busy, 0);
    chk({name, "_addr"},   bus.phase_addr, 3);
    chk({name, "_onehot"}, bus.phase_onehot, 0);
    chk({name, "_rem"},    bus.remaining, 0);
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    base = cyc;
  endtask

  // Scoreboard monitor: every slot-end pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.phase_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_phase_done cyc=%0d actual=1 required=0", cyc);
        end else begin
          e_mon = sb.pop_front();
          chk("pd_cycle",  cyc, e_mon.cyc);
          chk("pd_addr",   bus.phase_addr, e_mon.addr);
          chk("pd_onehot", bus.phase_onehot, e_mon.oh);
          chk("pd_frame",  bus.frame_done, e_mon.fd);
        end
      end else if (bus.frame_done) begin
        checks++;
        failures++;
        $display("FAIL lone_frame_done cyc=%0d actual=1 required=0", cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.hold = 0;
    bus.ch_en = 3'b000; bus.dur = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_pd", bus.phase_done, 0);
    chk("reset_fd", bus.frame_done, 0);
    rst_n = 1'b1;
    step();

    // Basic rotation: durations 0,1,2 on channels 0,1,2.
    bus.ch_en = 3'b111; bus.dur = {5'd2, 5'd1, 5'd0}; bus.tick = 1;
    do_start();
    push(base + 1, 1, 0); push(base + 3, 2, 0); push(base + 6, 0, 1); push(base + 7, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("rot_addr", bus.phase_addr, exp_addr1[i]);
      chk("rot_rem",  bus.remaining, exp_rem1[i]);
      chk("rot_busy", bus.busy, 1);
    end
    chk("rot_onehot", bus.phase_onehot, 3'b010);
    do_stop();
    chk("rot_stop_addr", bus.phase_addr, 3);

    // Skip channel 1.
    bus.ch_en = 3'b101; bus.dur = {5'd3, 5'd3, 5'd3};
    do_start();
    push(base + 4, 2, 0); push(base + 8, 0, 1); push(base + 12, 2, 0);
    chk("skip_addr0", bus.phase_addr, 0);
    repeat (4) step();
    chk("skip_addr2", bus.phase_addr, 2);
    chk("skip_rem", bus.remaining, 3);
    repeat (8) step();
    chk("skip_addr2b", bus.phase_addr, 2);
    do_stop();

    // Single enabled channel reselects itself.
    bus.ch_en = 3'b010;
    do_start();
    push(base + 4, 1, 1); push(base + 8, 1, 1);
    chk("single_addr", bus.phase_addr, 1);
    repeat (8) step();
    chk("single_addr_end", bus.phase_addr, 1);
    do_stop();

    // Hold with sparse ticks: only 5 unheld ticks end the slot.
    bus.ch_en = 3'b001; bus.dur = {5'd3, 5'd3, 5'd4}; bus.tick = 0;
    do_start();
    push(base + 19, 0, 1);
    for (int c = 0; c < 19; c++) begin
      bus.tick = ((c % 3) == 0);
      bus.hold = (c >= 4 && c <= 10);
      step();
      if (c == 3)  chk("hold_rem_pre", bus.remaining, 2);
      if (c == 10) chk("hold_rem_frozen", bus.remaining, 2);
      if (c == 12) chk("hold_rem_post", bus.remaining, 1);
      if (c == 17) chk("hold_rem_last", bus.remaining, 0);
      if (c == 18) chk("hold_rem_new", bus.remaining, 4);
    end
    bus.tick = 0; bus.hold = 0;
    do_stop();

    // Stop coincident with the slot-end tick wins; no pulse.
    bus.dur = {5'd3, 5'd3, 5'd0};
    do_start();
    bus.tick = 1; bus.stop = 1;
    step();
    bus.stop = 0; bus.tick = 0;
    chk_idle("stop_end");
    chk("stop_end_pd", bus.phase_done, 0);

    // start+stop together, and start with nothing enabled.
    bus.ch_en = 3'b111; bus.start = 1; bus.stop = 1;
    step();
    bus.start = 0; bus.stop = 0;
    chk("startstop_busy", bus.busy, 0);
    step();
    chk("startstop_busy2", bus.busy, 0);
    bus.ch_en = 3'b000;
    do_start();
    chk("noen_busy", bus.busy, 0);

    // Max duration; changing dur mid-slot does not alter the current slot.
    bus.ch_en = 3'b001; bus.dur = {5'd3, 5'd3, 5'd31}; bus.tick = 1;
    do_start();
    push(base + 32, 0, 1);
    chk("max_rem31", bus.remaining, 31);
    bus.dur = {5'd3, 5'd3, 5'd5};
    step();
    chk("max_rem30", bus.remaining, 30);
    repeat (19) step();
    chk("max_rem11", bus.remaining, 11);
    repeat (11) step();
    chk("max_rem0", bus.remaining, 0);
    chk("max_busy", bus.busy, 1);
    step();
    chk("max_newdur", bus.remaining, 5);
    do_stop();

    // Clearing ch_en mid-slot: slot completes, pulses, then idle.
    bus.ch_en = 3'b011; bus.dur = {5'd3, 5'd3, 5'd2};
    do_start();
    push(base + 3, 3, 1);
    bus.ch_en = 3'b000;
    repeat (2) step();
    chk("clr_busy", bus.busy, 1);
    step();
    chk_idle("clr_end");
    step();
    chk("clr_drain", sb.size(), 0);

    // Asynchronous reset mid-slot.
    bus.ch_en = 3'b001; bus.dur = {5'd3, 5'd3, 5'd10};
    do_start();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_pd", bus.phase_done, 0);
    #2 rst_n = 1'b1;
    repeat (5) step();
    chk("arst_busy_after", bus.busy, 0);
    chk("arst_addr_after", bus.phase_addr, 3);
    bus.tick = 0;

    step();
    chk("final_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
